// File: rtl/pad_output_bank.sv
// Bank of NCH output-pad controllers: registered data/enable with an enable dead time,
// push-pull or open-drain drive, per-channel attributes and loopback contention detection.
module pad_output_bank #(
  parameter int                 NCH      = 8,
  parameter int                 PADATTR  = 16,
  parameter int                 DEADTIME = 2,
  parameter logic [PADATTR-1:0] ATTR_RST = '0,
  parameter int                 AUTO_OFF = 1,
  parameter int                 CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NCH-1:0]         out_i,
  input  logic [NCH-1:0]         oe_i,
  output logic [NCH-1:0]         pad_in_o,
  output logic [NCH-1:0]         pad_oe_o,
  input  logic [NCH-1:0]         pad_out_i,
  output logic [NCH*PADATTR-1:0] pad_attributes_o,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [CHW-1:0]         cfg_ch_i,
  input  logic                   cfg_mode_i,
  input  logic [PADATTR-1:0]     cfg_attr_i,
  output logic [NCH-1:0]         err_o,
  input  logic [NCH-1:0]         err_clr_i
);

  localparam logic [3:0] DeadLoad = 4'(DEADTIME);
  localparam logic       AutoOff  = (AUTO_OFF != 0);

  typedef enum logic [1:0] {OFF = 2'd0, WAIT_ON = 2'd1, DRIVE = 2'd2} state_e;

  state_e                 state_q [NCH];
  state_e                 state_d [NCH];
  logic [3:0]             cnt_q   [NCH];
  logic [3:0]             cnt_d   [NCH];
  logic [NCH-1:0]         mode_q, mode_d;
  logic [NCH-1:0]         err_q, err_d;
  logic [NCH-1:0]         flag_q, flag_d;
  logic [NCH-1:0]         oe_q, oe_d;
  logic [NCH-1:0]         in_q, in_d;
  logic [NCH-1:0]         mis, cfg_sel, cfg_acc;
  logic [NCH*PADATTR-1:0] attr_q, attr_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NCH; k++) begin
        state_q[k] <= OFF;
        cnt_q[k]   <= '0;
      end
      mode_q <= '0;
      err_q  <= '0;
      flag_q <= '0;
      oe_q   <= '0;
      in_q   <= '0;
      attr_q <= {NCH{ATTR_RST}};
    end else begin
      for (int k = 0; k < NCH; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      mode_q <= mode_d;
      err_q  <= err_d;
      flag_q <= flag_d;
      oe_q   <= oe_d;
      in_q   <= in_d;
      attr_q <= attr_d;
    end
  end

  // A channel shut down by contention stays OFF until its error is cleared.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      unique case (state_q[k])
        OFF: begin
          if (oe_i[k] && (!err_q[k] || !AutoOff)) begin
            state_d[k] = WAIT_ON;
            cnt_d[k]   = DeadLoad;
          end
        end
        WAIT_ON: begin
          if (!oe_i[k])              state_d[k] = OFF;
          else if (cnt_q[k] == 4'd0) state_d[k] = DRIVE;
          else                       cnt_d[k]   = cnt_q[k] - 4'd1;
        end
        DRIVE: begin
          if (!oe_i[k] || (AutoOff && err_q[k])) state_d[k] = OFF;
        end
        default: state_d[k] = OFF;
      endcase
    end
  end

  always_comb begin
    cfg_ready_o = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      cfg_sel[k] = (32'(cfg_ch_i) == 32'(k));
      if (cfg_sel[k] && (state_q[k] != OFF)) cfg_ready_o = 1'b0;
    end
    for (int k = 0; k < NCH; k++) begin
      cfg_acc[k] = cfg_valid_i && cfg_ready_o && cfg_sel[k];
      mode_d[k]  = cfg_acc[k] ? cfg_mode_i : mode_q[k];
      attr_d[k*PADATTR +: PADATTR] = cfg_acc[k] ? cfg_attr_i : attr_q[k*PADATTR +: PADATTR];
      // Open-drain only drives low, so only a pad reading high while enabled is contention.
      mis[k]    = (state_q[k] == DRIVE) &&
                  (mode_q[k] ? (oe_q[k] && pad_out_i[k]) : (pad_out_i[k] != in_q[k]));
      flag_d[k] = mis[k] && (state_d[k] == DRIVE);
      err_d[k]  = (mis[k] && flag_q[k]) || (err_q[k] && !err_clr_i[k]);
      oe_d[k]   = (state_d[k] == DRIVE) && (!mode_d[k] || !out_i[k]);
      in_d[k]   = !mode_d[k] && out_i[k];
    end
  end

  assign pad_in_o         = in_q;
  assign pad_oe_o         = oe_q;
  assign err_o            = err_q;
  assign pad_attributes_o = attr_q;

endmodule

// File: tb/tb_pad_output_bank.sv
// Scoreboard bench for pad_output_bank: a run-length reference model predicts each edge's
// outputs into a queue that a negedge monitor drains and compares.
module tb_pad_output_bank;

  localparam int NCH      = 8;
  localparam int PADATTR  = 16;
  localparam int DEADTIME = 2;
  localparam int CHW      = 3;
  localparam int AUTO_OFF = 1;
  localparam int W        = NCH * PADATTR;
  localparam int FULL     = DEADTIME + 2;
  localparam logic [PADATTR-1:0] ATTR_RST = 16'h3C5A;

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH-1:0]     out_i, oe_i, pad_out_i, err_clr_i;
  logic [NCH-1:0]     pad_in_o, pad_oe_o, err_o;
  logic [W-1:0]       pad_attributes_o;
  logic               cfg_valid_i, cfg_ready_o, cfg_mode_i;
  logic [CHW-1:0]     cfg_ch_i;
  logic [PADATTR-1:0] cfg_attr_i;

  pad_output_bank #(
    .NCH(NCH), .PADATTR(PADATTR), .DEADTIME(DEADTIME),
    .ATTR_RST(ATTR_RST), .AUTO_OFF(AUTO_OFF), .CHW(CHW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .out_i(out_i), .oe_i(oe_i),
    .pad_in_o(pad_in_o), .pad_oe_o(pad_oe_o), .pad_out_i(pad_out_i),
    .pad_attributes_o(pad_attributes_o), .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o), .cfg_ch_i(cfg_ch_i), .cfg_mode_i(cfg_mode_i),
    .cfg_attr_i(cfg_attr_i), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] oe;
    logic [NCH-1:0] din;
    logic [NCH-1:0] err;
    logic [W-1:0]   attr;
    logic           ready;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: run[k] counts consecutive accepted enable cycles; the channel drives
  // once the count reaches DEADTIME+2 (first edge, DEADTIME waits, then the drive edge).
  int             run [NCH];
  logic [NCH-1:0] mMode, mErr, mFlag, mOe, mIn;
  logic [W-1:0]   mAttr;
  logic           mAccepted;

  logic [NCH-1:0]     dOut, dOe, dForce, dClr;
  logic               dV, dMode;
  logic [CHW-1:0]     dCh;
  logic [PADATTR-1:0] dAttr;
  int                 forceLeft [NCH];

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < NCH; k++) run[k] = 0;
    mMode = '0; mErr = '0; mFlag = '0; mOe = '0; mIn = '0;
    mAttr = {NCH{ATTR_RST}};
    mAccepted = 1'b0;
  endtask

  function automatic logic [NCH-1:0] loopback(input logic [NCH-1:0] f);
    logic [NCH-1:0] r;
    for (int k = 0; k < NCH; k++) r[k] = (mOe[k] ? mIn[k] : 1'b1) ^ f[k];
    return r;
  endfunction

  task automatic applyStimulus(input logic [NCH-1:0] o, input logic [NCH-1:0] e,
                               input logic [NCH-1:0] po, input logic [NCH-1:0] clr,
                               input logic v, input logic [CHW-1:0] ch,
                               input logic md, input logic [PADATTR-1:0] at);
    exp_t           x;
    int             nRun [NCH];
    int             chIdx;
    logic [NCH-1:0] nMode, nErr, nFlag, nOe, nIn;
    logic [W-1:0]   nAttr;
    bit             rdy, acc, drv, mis, blocked;
    @(negedge clk);
    #1;
    out_i = o; oe_i = e; pad_out_i = po; err_clr_i = clr;
    cfg_valid_i = v; cfg_ch_i = ch; cfg_mode_i = md; cfg_attr_i = at;
    chIdx = ch;
    rdy   = (chIdx >= NCH) || (run[chIdx] == 0);
    acc   = v && rdy && (chIdx < NCH);
    nMode = mMode;
    nAttr = mAttr;
    if (acc) begin
      nMode[chIdx] = md;
      nAttr[chIdx*PADATTR +: PADATTR] = at;
    end
    for (int k = 0; k < NCH; k++) begin
      drv     = run[k] >= FULL;
      blocked = mErr[k] && (AUTO_OFF != 0);
      mis     = drv && (mMode[k] ? (mOe[k] && po[k]) : (po[k] != mIn[k]));
      if (!e[k])               nRun[k] = 0;
      else if (run[k] == 0)    nRun[k] = blocked ? 0 : 1;
      else if (drv && blocked) nRun[k] = 0;
      else                     nRun[k] = (run[k] < FULL) ? run[k] + 1 : FULL;
      nFlag[k] = mis && (nRun[k] >= FULL);
      nErr[k]  = (mis && mFlag[k]) || (mErr[k] && !clr[k]);
      nOe[k]   = (nRun[k] >= FULL) && (!nMode[k] || !o[k]);
      nIn[k]   = !nMode[k] && o[k];
    end
    for (int k = 0; k < NCH; k++) run[k] = nRun[k];
    mMode = nMode; mErr = nErr; mFlag = nFlag; mOe = nOe; mIn = nIn; mAttr = nAttr;
    mAccepted = acc;
    x.oe    = nOe;
    x.din   = nIn;
    x.err   = nErr;
    x.attr  = nAttr;
    x.ready = (chIdx >= NCH) || (run[chIdx] == 0);
    expQ.push_back(x);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(dOut, dOe, loopback(dForce), dClr, dV, dCh, dMode, dAttr);
      if (mAccepted) dV = 1'b0;
    end
  endtask

  task automatic checkReset();
    checkOutput("reset_pad_oe", pad_oe_o, '0);
    checkOutput("reset_pad_in", pad_in_o, '0);
    checkOutput("reset_err", err_o, '0);
    checkOutput("reset_attr", pad_attributes_o, {NCH{ATTR_RST}});
    checkOutput("reset_ready", cfg_ready_o, 1);
  endtask

  task automatic clearInputs();
    out_i = '0; oe_i = '0; pad_out_i = '0; err_clr_i = '0;
    cfg_valid_i = 1'b0; cfg_ch_i = '0; cfg_mode_i = 1'b0; cfg_attr_i = '0;
    dOut = '0; dOe = '0; dForce = '0; dClr = '0; dV = 1'b0;
    for (int k = 0; k < NCH; k++) forceLeft[k] = 0;
  endtask

  // Reset asserted between clock edges; outputs must fall back without waiting for a clock.
  task automatic resetMid();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkReset();
    clearInputs();
    modelReset();
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("pad_oe", pad_oe_o, e.oe);
        checkOutput("pad_in", pad_in_o, e.din);
        checkOutput("err", err_o, e.err);
        checkOutput("attr", pad_attributes_o, e.attr);
        checkOutput("cfg_ready", cfg_ready_o, e.ready);
      end
    end
  end

  initial begin : driver
    int rise;
    rst = 1'b1;
    dCh = '0; dMode = 1'b0; dAttr = '0;
    clearInputs();
    modelReset();
    #12;
    checkReset();
    @(negedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] enable latency on ch0");
    dOut[0] = 1'b1; dOe[0] = 1'b1;
    rise = -1;
    for (int j = 1; j <= 8; j++) begin
      step(1);
      if (rise < 0 && pad_oe_o[0]) rise = j - 2;
    end
    checkOutput("enable_latency", rise, DEADTIME + 1);
    dOe[0] = 1'b0;
    step(2);

    $display("[TB] aborted enable on ch4");
    dOe[4] = 1'b1; step(2);
    dOe[4] = 1'b0; step(4);

    $display("[TB] config held while ch3 drives");
    dOe[3] = 1'b1; step(5);
    dV = 1'b1; dCh = 3'd3; dMode = 1'b0; dAttr = 16'hA5A5; step(3);
    dOe[3] = 1'b0; step(3);

    $display("[TB] open-drain ch1");
    dV = 1'b1; dCh = 3'd1; dMode = 1'b1; dAttr = 16'h0101; step(2);
    dOe[1] = 1'b1; dOut[1] = 1'b0; step(5);
    dOut[1] = 1'b1; step(1);
    dOut[1] = 1'b0; step(1);
    dOut[1] = 1'b1; step(2);
    dOe[1] = 1'b0; step(1);

    $display("[TB] contention on ch2");
    dOe[2] = 1'b1; dOut[2] = 1'b1; step(5);
    dForce[2] = 1'b1; step(2);
    dForce[2] = 1'b0; step(4);
    dClr[2] = 1'b1; step(1);
    dClr[2] = 1'b0; step(6);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 600; c++) begin
      if (c == 300) resetMid();
      if (!dV && $urandom_range(0, 3) == 0) begin
        dV    = 1'b1;
        dCh   = CHW'($urandom_range(0, NCH - 1));
        dMode = 1'($urandom_range(0, 1));
        dAttr = PADATTR'($urandom);
      end
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(0, 9) == 0) dOe[k] = ~dOe[k];
        if (forceLeft[k] == 0 && $urandom_range(0, 24) == 0) forceLeft[k] = $urandom_range(1, 3);
        dForce[k] = (forceLeft[k] > 0);
        if (forceLeft[k] > 0) forceLeft[k]--;
        dClr[k] = ($urandom_range(0, 11) == 0);
      end
      dOut = NCH'($urandom);
      step(1);
    end

    repeat (4) @(negedge clk);
    #1;
    checkOutput("queue_drained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
